// File: rtl/crc5_t.sv
// Transmit-side USB token/handshake serialiser: PID byte, optional token field bytes with CRC5.
// Optional CRC5_T_ERRINJ_EN adds err_inj, which corrupts one CRC bit of token packets.
module crc5_t #(
    parameter logic [4:0]  CRC_INIT   = 5'h1F,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_pid,
    input  logic [10:0] req_field,
`ifdef CRC5_T_ERRINJ_EN
    input  logic        err_inj,
`endif
    output logic        req_err,
    output logic        tx_lp_sop,
    output logic        tx_lp_eop,
    output logic        tx_lp_valid,
    output logic [7:0]  tx_lp_data,
    input  logic        tx_lp_ready,
    output logic        busy
);

    typedef enum logic [2:0] {StIdle, StPid, StTok1, StTok2, StGap} state_e;

    localparam logic [3:0] GapLoad = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam state_e     PostEop = (GAP_CYCLES == 0) ? StIdle : StGap;

    state_e      state_q, state_d;
    logic [3:0]  pid_q, pid_d;
    logic [10:0] field_q, field_d;
    logic [4:0]  crc_q, crc_d;
    logic        tok_q, tok_d;
    logic [3:0]  gap_q, gap_d;
    logic        err_q, err_d;

    logic        pid_tok, pid_hs;
    logic [4:0]  crc_calc;

    // Returns the on-wire CRC field: complemented remainder, remainder MSB in field bit 0.
    function automatic logic [4:0] crc5_field(input logic [10:0] field);
        logic [4:0] c;
        logic       fb;
        logic [4:0] res;
        c = CRC_INIT;
        for (int i = 0; i < 11; i++) begin
            fb = field[i] ^ c[4];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        for (int i = 0; i < 5; i++) begin
            res[i] = ~c[4-i];
        end
        return res;
    endfunction

    always_comb begin
        pid_tok = 1'b0;
        pid_hs  = 1'b0;
        case (req_pid)
            4'b0001, 4'b1001, 4'b0101, 4'b1101, 4'b0100: pid_tok = 1'b1;
            4'b0010, 4'b1010, 4'b1110, 4'b0110, 4'b1100: pid_hs  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        crc_calc = crc5_field(req_field);
`ifdef CRC5_T_ERRINJ_EN
        crc_calc[0] = crc_calc[0] ^ err_inj;
`endif
    end

    always_comb begin
        state_d     = state_q;
        pid_d       = pid_q;
        field_d     = field_q;
        crc_d       = crc_q;
        tok_d       = tok_q;
        gap_d       = gap_q;
        err_d       = 1'b0;
        req_ready   = 1'b0;
        tx_lp_valid = 1'b0;
        tx_lp_sop   = 1'b0;
        tx_lp_eop   = 1'b0;
        tx_lp_data  = 8'h00;
        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (pid_tok || pid_hs) begin
                        pid_d   = req_pid;
                        field_d = req_field;
                        crc_d   = crc_calc;
                        tok_d   = pid_tok;
                        state_d = StPid;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StPid: begin
                tx_lp_valid = 1'b1;
                tx_lp_sop   = 1'b1;
                tx_lp_eop   = ~tok_q;
                tx_lp_data  = {~pid_q, pid_q};
                if (tx_lp_ready) begin
                    if (tok_q) begin
                        state_d = StTok1;
                    end else begin
                        state_d = PostEop;
                        gap_d   = GapLoad;
                    end
                end
            end
            StTok1: begin
                tx_lp_valid = 1'b1;
                tx_lp_data  = field_q[7:0];
                if (tx_lp_ready) state_d = StTok2;
            end
            StTok2: begin
                tx_lp_valid = 1'b1;
                tx_lp_eop   = 1'b1;
                tx_lp_data  = {crc_q, field_q[10:8]};
                if (tx_lp_ready) begin
                    state_d = PostEop;
                    gap_d   = GapLoad;
                end
            end
            StGap: begin
                if (gap_q == 4'd0) state_d = StIdle;
                else               gap_d   = gap_q - 4'd1;
            end
            default: state_d = StIdle;
        endcase
        // Keep the request port quiet while reset is held.
        if (rst) req_ready = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pid_q   <= 4'h0;
            field_q <= 11'h000;
            crc_q   <= 5'h00;
            tok_q   <= 1'b0;
            gap_q   <= 4'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pid_q   <= pid_d;
            field_q <= field_d;
            crc_q   <= crc_d;
            tok_q   <= tok_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
        end
    end

    assign req_err = err_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_crc5_t.sv
// Self-checking bench for crc5_t: directed packets, rejects, reset abort and randomised tokens
// with PHY stalls against a polynomial-division CRC5 model.
module tb_crc5_t;

    localparam logic [4:0]  CrcInit = 5'h1F;
    localparam int unsigned Gap     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_pid = 4'h0;
    logic [10:0] req_field = 11'h000;
    logic        req_err;
    logic        tx_lp_sop, tx_lp_eop, tx_lp_valid;
    logic [7:0]  tx_lp_data;
    logic        tx_lp_ready = 1'b0;
    logic        busy;
`ifdef CRC5_T_ERRINJ_EN
    logic        err_inj = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    crc5_t #(
        .CRC_INIT  (CrcInit),
        .GAP_CYCLES(Gap)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pid    (req_pid),
        .req_field  (req_field),
`ifdef CRC5_T_ERRINJ_EN
        .err_inj    (err_inj),
`endif
        .req_err    (req_err),
        .tx_lp_sop  (tx_lp_sop),
        .tx_lp_eop  (tx_lp_eop),
        .tx_lp_valid(tx_lp_valid),
        .tx_lp_data (tx_lp_data),
        .tx_lp_ready(tx_lp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Remainder of (field, bit 0 leading, preset folded into the first five bits) * x^5 mod x^5+x^2+1.
    function automatic logic [4:0] model_rem(input logic [10:0] field);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 11; i++) v = {v[14:0], field[i]};
        v[10:6] = v[10:6] ^ CrcInit;
        v = v << 5;
        for (int i = 15; i >= 5; i--) begin
            if (v[i]) v = v ^ (16'h0025 << (i - 5));
        end
        return v[4:0];
    endfunction

    function automatic logic [7:0] model_byte2(input logic [10:0] f, input logic inj);
        logic [4:0] t, r;
        t = ~model_rem(f);
        for (int i = 0; i < 5; i++) r[i] = t[4-i];
        return {r, f[10:8]} ^ (inj ? 8'h08 : 8'h00);
    endfunction

    function automatic logic [7:0] pid_byte(input logic [3:0] p);
        return {~p, p};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({req_ready, req_err, tx_lp_valid, tx_lp_sop, tx_lp_eop, busy, tx_lp_data} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {req_ready, req_err, tx_lp_valid,
                     tx_lp_sop, tx_lp_eop, busy, tx_lp_data});
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req_ready, busy, req_err} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_release: got %b required 100", {req_ready, busy, req_err});
        end
    endtask

    task automatic test_setup_zero();
        logic [10:0] exp [3];
        exp[0] = {3'b110, 8'h2D};
        exp[1] = {3'b100, 8'h00};
        exp[2] = {3'b101, 8'h10};
        tx_lp_ready = 1'b1;
        req_pid     = 4'b1101;
        req_field   = 11'h000;
        req_valid   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data} !== exp[i]) begin
                n_fail++;
                $display("FAIL setup_beat%0d: got %h required %h", i,
                         {tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data}, exp[i]);
            end
            @(negedge clk);
        end
        for (int i = 0; i < int'(Gap); i++) begin
            n_checks++;
            if ({req_ready, tx_lp_valid, busy} !== 3'b001) begin
                n_fail++;
                $display("FAIL setup_gap%0d: got %b required 001", i, {req_ready, tx_lp_valid, busy});
            end
            @(negedge clk);
        end
        n_checks++;
        if ({req_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL setup_idle: got %b required 10", {req_ready, busy});
        end
    endtask

    task automatic test_ack_gap();
        int k;
        tx_lp_ready = 1'b1;
        req_pid     = 4'b0010;
        req_valid   = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data} !== {3'b111, 8'hD2}) begin
            n_fail++;
            $display("FAIL ack_beat: got %h required %h",
                     {tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data}, {3'b111, 8'hD2});
        end
        req_pid = 4'b1010;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
            n_checks++;
            if (tx_lp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ack_gap_valid: got %b required 0", tx_lp_valid);
            end
        end
        n_checks++;
        if (k != int'(Gap) + 1) begin
            n_fail++;
            $display("FAIL ack_accept_delay: got %0d cycles required %0d", k, Gap + 1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if ({tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data} !== {3'b111, 8'h5A}) begin
            n_fail++;
            $display("FAIL nak_beat: got %h required %h",
                     {tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data}, {3'b111, 8'h5A});
        end
        repeat (Gap + 1) @(negedge clk);
    endtask

    task automatic test_reject();
        logic [3:0] bad [2];
        bad[0] = 4'b0011;
        bad[1] = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            req_pid   = bad[i];
            req_valid = 1'b1;
            @(negedge clk);
            req_valid = 1'b0;
            n_checks++;
            if ({req_err, tx_lp_valid, busy, req_ready} !== 4'b1001) begin
                n_fail++;
                $display("FAIL reject%0d_pulse: got %b required 1001", i,
                         {req_err, tx_lp_valid, busy, req_ready});
            end
            @(negedge clk);
            n_checks++;
            if ({req_err, tx_lp_valid, busy, req_ready} !== 4'b0001) begin
                n_fail++;
                $display("FAIL reject%0d_after: got %b required 0001", i,
                         {req_err, tx_lp_valid, busy, req_ready});
            end
        end
        tx_lp_ready = 1'b1;
        req_pid     = 4'b0001;
        req_field   = 11'($urandom);
        req_valid   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if ({tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data} !== {3'b110, 8'hE1}) begin
            n_fail++;
            $display("FAIL reject_next_pkt: got %h required %h",
                     {tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data}, {3'b110, 8'hE1});
        end
        repeat (2 + Gap + 1) @(negedge clk);
    endtask

    task automatic test_random_tokens();
        logic [3:0]  toks [4];
        logic [10:0] q [$];
        logic [3:0]  p;
        logic [10:0] f;
        bit          accepted, acc_now;
        int          cycles;
        toks[0] = 4'b0001;
        toks[1] = 4'b1001;
        toks[2] = 4'b0101;
        toks[3] = 4'b0100;
        for (int n = 0; n < 40; n++) begin
            p = toks[$urandom_range(0, 3)];
            f = 11'($urandom);
            q.push_back({3'b110, pid_byte(p)});
            q.push_back({3'b100, f[7:0]});
            q.push_back({3'b101, model_byte2(f, 1'b0)});
            req_pid   = p;
            req_field = f;
            req_valid = 1'b1;
            accepted  = 1'b0;
            cycles    = 0;
            while (q.size() != 0 && cycles < 200) begin
                acc_now = req_valid && req_ready;
                if (tx_lp_valid) begin
                    n_checks++;
                    if (!accepted || {tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data} !== q[0]) begin
                        n_fail++;
                        $display("FAIL rand_beat pkt %0d: got %h required %h (accepted=%0d)", n,
                                 {tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data}, q[0], accepted);
                    end
                end
                tx_lp_ready = ($urandom_range(0, 2) != 0);
                if (tx_lp_valid && tx_lp_ready) void'(q.pop_front());
                @(negedge clk);
                cycles++;
                if (acc_now) begin
                    accepted  = 1'b1;
                    req_valid = 1'b0;
                end
            end
            n_checks++;
            if (q.size() != 0) begin
                n_fail++;
                $display("FAIL rand_timeout pkt %0d: got %0d beats left required 0", n, q.size());
            end
            q.delete();
            req_valid = 1'b0;
        end
        tx_lp_ready = 1'b1;
        repeat (Gap + 1) @(negedge clk);
    endtask

    task automatic test_rst_mid();
        logic [10:0] f;
        logic [10:0] exp [3];
        tx_lp_ready = 1'b1;
        req_pid     = 4'b0001;
        req_field   = 11'($urandom);
        f           = req_field;
        req_valid   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        tx_lp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data} !== {3'b100, f[7:0]}) begin
            n_fail++;
            $display("FAIL rst_tok1_stall: got %h required %h",
                     {tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data}, {3'b100, f[7:0]});
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({tx_lp_valid, busy, req_ready, tx_lp_sop, tx_lp_eop} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_async: got %b required 00000",
                     {tx_lp_valid, busy, req_ready, tx_lp_sop, tx_lp_eop});
        end
        @(negedge clk);
        rst         = 1'b0;
        tx_lp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({tx_lp_valid, busy, req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL rst_after: got %b required 001", {tx_lp_valid, busy, req_ready});
        end
        f         = 11'($urandom);
        exp[0]    = {3'b110, pid_byte(4'b1001)};
        exp[1]    = {3'b100, f[7:0]};
        exp[2]    = {3'b101, model_byte2(f, 1'b0)};
        req_pid   = 4'b1001;
        req_field = f;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data} !== exp[i]) begin
                n_fail++;
                $display("FAIL rst_in_beat%0d: got %h required %h", i,
                         {tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data}, exp[i]);
            end
            @(negedge clk);
        end
        repeat (Gap) @(negedge clk);
    endtask

`ifdef CRC5_T_ERRINJ_EN
    task automatic test_errinj();
        logic [10:0] exp [3];
        exp[0] = {3'b110, 8'h2D};
        exp[1] = {3'b100, 8'h00};
        exp[2] = {3'b101, 8'h18};
        tx_lp_ready = 1'b1;
        err_inj     = 1'b1;
        req_pid     = 4'b1101;
        req_field   = 11'h000;
        req_valid   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data} !== exp[i]) begin
                n_fail++;
                $display("FAIL errinj_beat%0d: got %h required %h", i,
                         {tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data}, exp[i]);
            end
            @(negedge clk);
        end
        repeat (Gap) @(negedge clk);
        req_pid   = 4'b0010;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if ({tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data} !== {3'b111, 8'hD2}) begin
            n_fail++;
            $display("FAIL errinj_ack: got %h required %h",
                     {tx_lp_valid, tx_lp_sop, tx_lp_eop, tx_lp_data}, {3'b111, 8'hD2});
        end
        err_inj = 1'b0;
        repeat (Gap + 1) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_setup_zero();
        test_ack_gap();
        test_reject();
        test_random_tokens();
        test_rst_mid();
`ifdef CRC5_T_ERRINJ_EN
        test_errinj();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
